// File: rtl/act_stage.sv
// Activation stage: applies bypass / ReLU / leaky ReLU (slope 1/8) to single-precision
// weighted sums, buffered by a main output register plus one skid register.
module act_stage #(
    parameter int NEURONS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  mode,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_last
);

    localparam int CW = (NEURONS > 1) ? $clog2(NEURONS) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(NEURONS - 1);

    logic          main_valid_q, main_valid_d;
    logic [31:0]   main_data_q,  main_data_d;
    logic          main_last_q,  main_last_d;
    logic          skid_valid_q, skid_valid_d;
    logic [31:0]   skid_data_q,  skid_data_d;
    logic          skid_last_q,  skid_last_d;
    logic          in_ready_q,   in_ready_d;
    logic [CW-1:0] cnt_q,        cnt_d;

    logic          accept;
    logic          drain;
    logic          new_last;
    logic [31:0]   act_word;
    logic [7:0]    in_exp;
    logic          in_nan;

    assign accept   = in_valid && in_ready_q;
    assign drain    = main_valid_q && out_ready;
    assign new_last = (cnt_q == CNT_MAX);
    assign in_exp   = in_data[30:23];
    assign in_nan   = (in_exp == 8'hFF) && (in_data[22:0] != 23'd0);

    // Activation is evaluated at acceptance so the word is stored already transformed.
    always_comb begin
        act_word = in_data;
        if (mode != 2'b00) begin
            if (in_nan) begin
                act_word = 32'h7FC0_0000;
            end else if (in_data[31]) begin
                if (mode == 2'b10) begin
                    if (in_exp == 8'hFF) begin
                        act_word = in_data;
                    end else if (in_exp < 8'd4) begin
                        act_word = 32'h8000_0000;
                    end else begin
                        act_word = {1'b1, in_exp - 8'd3, in_data[22:0]};
                    end
                end else begin
                    act_word = 32'h0000_0000;
                end
            end
        end
    end

    // Skid never holds a word while main is empty, so it only ever refills main.
    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        main_last_d  = main_last_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_last_d  = skid_last_q;
        cnt_d        = cnt_q;

        if (skid_valid_q) begin
            if (drain) begin
                main_valid_d = 1'b1;
                main_data_d  = skid_data_q;
                main_last_d  = skid_last_q;
                skid_valid_d = 1'b0;
            end
        end else if (!main_valid_q || drain) begin
            main_valid_d = accept;
            if (accept) begin
                main_data_d = act_word;
                main_last_d = new_last;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_data_d  = act_word;
            skid_last_d  = new_last;
        end

        if (accept) begin
            cnt_d = new_last ? '0 : cnt_q + 1'b1;
        end

        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            main_data_q  <= 32'h0;
            main_last_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= 32'h0;
            skid_last_q  <= 1'b0;
            in_ready_q   <= 1'b0;
            cnt_q        <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            main_last_q  <= main_last_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_last_q  <= skid_last_d;
            in_ready_q   <= in_ready_d;
            cnt_q        <= cnt_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = main_valid_q;
    assign out_data  = main_data_q;
    assign out_last  = main_last_q;

endmodule

// File: tb/tb_act_stage.sv
// Self-checking bench for act_stage: a queue-based reference model is checked every cycle,
// with directed literal cases and a long randomized valid/ready/mode run.
module tb_act_stage;

    localparam int NEURONS = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  mode;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } item_t;

    item_t       expQ[$];
    int          modelCnt = 0;
    int          accepts = 0;
    int          drains = 0;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] lastHist = 32'h0;
    logic        sawEdge = 1'b0;

    act_stage #(.NEURONS(NEURONS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s got %h want %h at %0t", name, got, want, $time);
        end
    endtask

    // Reference activation written directly from the sign/exponent/mantissa rules.
    function automatic logic [31:0] refAct(input logic [31:0] x, input logic [1:0] md);
        int  expo;
        bit  neg;
        bit  isNan;
        expo  = int'(x[30:23]);
        neg   = x[31];
        isNan = (expo == 255) && (x[22:0] != 0);
        if (md == 2'b00) return x;
        if (isNan) return 32'h7FC00000;
        if (!neg) return x;
        if (md == 2'b10) begin
            if (expo == 255) return x;
            if (expo < 4) return 32'h80000000;
            return {1'b1, 8'(expo - 3), x[22:0]};
        end
        return 32'h0;
    endfunction

    function automatic logic [31:0] randWord();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 5))
            0: w = $urandom;
            1: w = {w[31], 8'hFF, (w[22:0] == 0) ? 23'd1 : w[22:0]};
            2: w = {w[31], w[0] ? 8'hFF : 8'h00, 23'd0};
            3: w = {1'b1, 8'($urandom_range(0, 5)), w[22:0]};
            4: w = {1'b1, w[30:0]};
            default: w = {1'b0, w[30:0]};
        endcase
        return w;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) sawEdge <= 1'b0;
        else        sawEdge <= 1'b1;
    end

    // Cycle monitor: outputs reflect model state before this cycle's handshakes.
    always @(negedge clk) begin
        if (!rst_n) begin
            expQ.delete();
            modelCnt = 0;
            checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
            checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd0);
            checkOutput("rst_out_data", out_data, 32'h0);
            checkOutput("rst_out_last", {31'd0, out_last}, 32'd0);
        end else begin
            checkOutput("in_ready", {31'd0, in_ready}, {31'd0, sawEdge && (expQ.size() < 2)});
            checkOutput("out_valid", {31'd0, out_valid}, {31'd0, expQ.size() > 0});
            if (out_valid && expQ.size() > 0) begin
                checkOutput("out_data", out_data, expQ[0].data);
                checkOutput("out_last", {31'd0, out_last}, {31'd0, expQ[0].last});
                if (out_ready) begin
                    lastHist = {lastHist[30:0], out_last};
                    drains++;
                    expQ.delete(0);
                end
            end
            if (in_valid && in_ready) begin
                expQ.push_back('{refAct(in_data, mode), modelCnt == NEURONS - 1});
                modelCnt = (modelCnt + 1) % NEURONS;
                accepts++;
            end
        end
    end

    task automatic applyReset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic sendWord(input logic [31:0] w, input logic [1:0] md);
        bit ok;
        ok = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data = w;
        mode = md;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) checkOutput("send_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic expectLiteral(input string name, input logic [31:0] want);
        @(negedge clk);
        checkOutput({name, "_valid"}, {31'd0, out_valid}, 32'd1);
        checkOutput(name, out_data, want);
    endtask

    task automatic applyStimulus(input int words);
        int startA;
        int cyc;
        startA = accepts;
        cyc = 0;
        while ((accepts - startA) < words && cyc < 60000) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 9) < 6);
            in_data   = randWord();
            mode      = 2'($urandom_range(0, 3));
            out_ready = ($urandom_range(0, 9) < 7);
            cyc++;
        end
        if ((accepts - startA) < words) checkOutput("random_timeout", accepts - startA, words);
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("random_drained", expQ.size(), 32'd0);
    endtask

    logic [31:0] v1In[4]  = '{32'h3F800000, 32'hBF800000, 32'h80000000, 32'h7FC00001};
    logic [31:0] v1Out[4] = '{32'h3F800000, 32'h00000000, 32'h00000000, 32'h7FC00000};
    logic [31:0] v2In[3]  = '{32'hC0000000, 32'h81000000, 32'hFF800000};
    logic [31:0] v2Out[3] = '{32'hBE800000, 32'h80000000, 32'hFF800000};

    initial begin
        int startA;
        int startD;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_data = 32'h0;
        mode = 2'b00;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        checkOutput("ref_leaky_neg2", refAct(32'hC0000000, 2'b10), 32'hBE800000);
        checkOutput("ref_relu_nan", refAct(32'hFFC00123, 2'b11), 32'h7FC00000);
        checkOutput("ref_bypass_nan", refAct(32'hFFC00123, 2'b00), 32'hFFC00123);
        checkOutput("ref_leaky_small", refAct(32'h81FFFFFF, 2'b10), 32'h80000000);

        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sendWord(v1In[i], 2'b01);
            expectLiteral("v1_relu", v1Out[i]);
        end
        for (int i = 0; i < 3; i++) begin
            sendWord(v2In[i], 2'b10);
            expectLiteral("v2_leaky", v2Out[i]);
        end

        applyReset();
        out_ready = 1'b1;
        startD = drains;
        startA = accepts;
        mode = 2'b00;
        in_valid = 1'b1;
        for (int i = 0; i < 50 && (accepts - startA) < 9; i++) begin
            in_data = $urandom;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("v3_drains", drains - startD, 32'd9);
        checkOutput("v3_last_pattern", {23'd0, lastHist[8:0]}, 32'b000100010);

        applyReset();
        out_ready = 1'b0;
        startA = accepts;
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_data = 32'h40000000 + i;
            @(posedge clk); #1;
        end
        checkOutput("v4_accepts", accepts - startA, 32'd2);
        @(negedge clk);
        checkOutput("v4_in_ready_low", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        startD = drains;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("v4_drains", drains - startD, 32'd2);

        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 32'hC0400000;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("v5_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("v5_in_ready", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        sendWord(32'h3F800000, 2'b01);
        @(negedge clk);
        checkOutput("v5_first_data", out_data, 32'h3F800000);
        checkOutput("v5_first_last", {31'd0, out_last}, 32'd0);
        for (int i = 0; i < 3; i++) sendWord(32'h3F800000 + i + 1, 2'b01);
        @(negedge clk);
        checkOutput("v5_fourth_last", {31'd0, out_last}, 32'd1);

        applyStimulus(10000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1500000;
        $display("[TB] FAIL watchdog got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/act_stage.md
ACT_STAGE -- requirements
Module: act_stage

Interface
- REQ-001 SHALL have parameter NEURONS, default 4: number of neuron results per layer; out_last marks the NEURONS-th accepted result.
- REQ-002 SHALL have port clk, input, 1: sole clock, rising edge.
- REQ-003 SHALL have port rst_n, input, 1: asynchronous active-low reset.
- REQ-004 SHALL have port mode, input, 2: 00 bypass, 01 ReLU, 10 leaky ReLU (slope 1/8), 11 treated as 01.
- REQ-005 SHALL have port in_valid, input, 1: in_data valid from upstream weighted-sum stage.
- REQ-006 SHALL have port in_ready, output, 1: stage can accept in_data this cycle.
- REQ-007 SHALL have port in_data, input, 32: IEEE-754 single-precision weighted sum.
- REQ-008 SHALL have port out_valid, output, 1: out_data/out_last valid.
- REQ-009 SHALL have port out_ready, input, 1: downstream accepts this cycle.
- REQ-010 SHALL have port out_data, output, 32: activated IEEE-754 single value.
- REQ-011 SHALL have port out_last, output, 1: high with the final neuron result of a layer.

Function
- REQ-012 SHALL accept a word on a cycle where in_valid && in_ready; SHALL transfer out on out_valid && out_ready.
- REQ-013 SHALL provide a main output register plus one skid register (2 entries total); in_ready SHALL be a registered signal, high iff the skid register is empty.
- REQ-014 SHALL present an accepted word on out_data one cycle after acceptance when the main register is empty or drains in the same cycle (latency 1).
- REQ-015 SHALL, when main is full and not draining, store the accepted word in skid; skid SHALL move to main on the next drain, preserving order.
- REQ-016 SHALL never drop, duplicate or reorder words; out_data/out_last SHALL hold stable while out_valid && !out_ready.
- REQ-017 SHALL sample mode together with in_data at acceptance; mode changes affect only later words.
- REQ-018 Bypass: out = in, bit-exact.
- REQ-019 ReLU: sign=0 non-NaN -> unchanged; sign=1 non-NaN (incl. -0.0, -Inf) -> 0x00000000.
- REQ-020 Leaky: sign=0 -> unchanged; sign=1 with exponent field e in 4..254 -> exponent e-3, sign and mantissa unchanged; e in 0..3 -> 0x80000000; -Inf (0xFF800000) -> unchanged.
- REQ-021 NaN input (e=255, mantissa!=0) SHALL produce 0x7FC00000 in modes 01/10/11; unchanged in bypass.
- REQ-022 SHALL keep a neuron counter 0..NEURONS-1, incremented on each accept, wrapping to 0 after NEURONS-1; out_last SHALL travel with the word accepted at count NEURONS-1.
- REQ-023 Simultaneous accept and drain with both registers full SHALL not occur (in_ready low); with main full, skid empty: drained word leaves, new word enters main.

Reset
- REQ-024 On rst_n low, asynchronously: out_valid=0, out_last=0, out_data=0x00000000, in_ready=0, skid empty, counter=0.
- REQ-025 in_ready SHALL rise on the first clk edge after rst_n deasserts; reset mid-transfer SHALL discard both buffered words and restart counting at 0.

Verification
- V1: mode=01, out_ready=1, stream 0x3F800000, 0xBF800000, 0x80000000, 0x7FC00001 -> outputs 0x3F800000, 0x00000000, 0x00000000, 0x7FC00000, each 1 cycle after accept.
- V2: mode=10, 0xC0000000 (-2.0) -> 0xBE800000 (-0.25); 0x81000000 (e=2) -> 0x80000000; 0xFF800000 -> 0xFF800000.
- V3: NEURONS=4, 9 accepts back-to-back -> out_last high on 4th and 8th outputs only.
- V4: out_ready=0, in_valid=1 continuously -> exactly 2 words accepted, in_ready low from the cycle after 2nd accept; release out_ready -> both emitted in order, stable while stalled.
- V5: rst_n low while both registers full -> out_valid=0 immediately; after release, next accepted word is neuron 0 and no old word appears.
- V6: random valid/ready with random mode, 10k words -> output sequence equals reference-model sequence, no loss/duplication.
